// File: rtl/rv32i_irq_seq_pkg.sv
// Shared state encoding and defaults for the rv32i interrupt stimulus sequencer.
package rv32i_irq_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ASSERT = 2'd2,
    DONE   = 2'd3
  } ch_state_t;

  localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/rv32i_irq_seq_channel.sv
// One interrupt channel: delayed request, optional periodic re-arm, ack-cleared.
// Optional IRQ_SEQ_TIMEOUT_EN drops an unacknowledged request and flags it.
//
// state  | meaning
// IDLE   | never programmed since reset, no request
// ARMED  | counting the delay/period down to zero
// ASSERT | request held until ack (or timeout)
// DONE   | one-shot finished or timed out, waiting for reprogramming
module rv32i_irq_seq_channel
  import rv32i_irq_seq_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             ack,
  output logic             irq,
  output logic             busy,
  output logic             timeout
);

  ch_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] period_reg, period_nxt;
  logic             irq_nxt;

`ifdef IRQ_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          timeout_nxt;
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    period_nxt = period_reg;
    irq_nxt    = irq;
`ifdef IRQ_SEQ_TIMEOUT_EN
    tcnt_nxt    = tcnt;
    timeout_nxt = timeout;
`endif
    if (cfg_wr) begin
      state_nxt  = ARMED;
      cnt_nxt    = cfg_delay;
      period_nxt = cfg_period;
      irq_nxt    = 1'b0;
`ifdef IRQ_SEQ_TIMEOUT_EN
      tcnt_nxt   = '0;
`endif
    end else begin
      case (state)
        ARMED: begin
          if (cnt == '0) begin
            state_nxt = ASSERT;
            irq_nxt   = 1'b1;
`ifdef IRQ_SEQ_TIMEOUT_EN
            tcnt_nxt  = '0;
`endif
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        ASSERT: begin
          if (ack) begin
            irq_nxt = 1'b0;
            if (period_reg != '0) begin
              state_nxt = ARMED;
              cnt_nxt   = period_reg;
            end else begin
              state_nxt = DONE;
            end
          end
`ifdef IRQ_SEQ_TIMEOUT_EN
          // an ack on the terminal edge takes precedence over the timeout
          else if (tcnt == TW'(TIMEOUT - 1)) begin
            state_nxt   = DONE;
            irq_nxt     = 1'b0;
            timeout_nxt = 1'b1;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      period_reg <= '0;
      irq        <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      period_reg <= period_nxt;
      irq        <= irq_nxt;
    end
  end

`ifdef IRQ_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      tcnt    <= tcnt_nxt;
      timeout <= timeout_nxt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign busy = (state == ARMED) || (state == ASSERT);

endmodule

// File: rtl/rv32i_irq_sequencer.sv
// Top level: NUM_CH independent interrupt stimulus channels with cfg/ack decode.
// Optional IRQ_SEQ_TIMEOUT_EN adds per-channel sticky no-ack timeout flags.
module rv32i_irq_sequencer
  import rv32i_irq_seq_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int CNT_W     = 32,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT,
  localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_wr,
  input  logic [SEL_W-1:0]  i_cfg_sel,
  input  logic [CNT_W-1:0]  i_cfg_delay,
  input  logic [CNT_W-1:0]  i_cfg_period,
  input  logic              i_ack_valid,
  input  logic [SEL_W-1:0]  i_ack_ch,
  output logic [NUM_CH-1:0] o_irq,
  output logic              o_busy,
  output logic [NUM_CH-1:0] o_timeout
);

  logic [NUM_CH-1:0] ch_busy;

  // out-of-range indices match no channel, so they fall through as no-ops
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic cfg_hit;
    logic ack_hit;

    assign cfg_hit = i_cfg_wr    && (i_cfg_sel == SEL_W'(i));
    assign ack_hit = i_ack_valid && (i_ack_ch  == SEL_W'(i));

    rv32i_irq_seq_channel #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
    ) u_channel (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .cfg_wr     (cfg_hit),
      .cfg_delay  (i_cfg_delay),
      .cfg_period (i_cfg_period),
      .ack        (ack_hit),
      .irq        (o_irq[i]),
      .busy       (ch_busy[i]),
      .timeout    (o_timeout[i])
    );
  end

  assign o_busy = |ch_busy;

endmodule

// File: tb/tb_rv32i_irq_sequencer.sv
// Scoreboard bench for rv32i_irq_sequencer: directed scenarios plus random cfg/ack traffic.
module tb_rv32i_irq_sequencer;

  localparam int NCH = 3;
  localparam int TMO = 16;
`ifdef IRQ_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // channel view used by the reference model: absolute edge times, not counters
  localparam int M_OFF  = 0;
  localparam int M_WAIT = 1;
  localparam int M_HIGH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_sel = 2'd0;
  logic [31:0] cfg_delay = 32'd0;
  logic [31:0] cfg_period = 32'd0;
  logic        ack_valid = 1'b0;
  logic [1:0]  ack_ch = 2'd0;
  logic [2:0]  irq;
  logic        busy;
  logic [2:0]  tmo;

  always #5 clk = ~clk;

  rv32i_irq_sequencer #(
    .NUM_CH  (NCH),
    .CNT_W   (32),
    .TIMEOUT (TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cfg_wr     (cfg_wr),
    .i_cfg_sel    (cfg_sel),
    .i_cfg_delay  (cfg_delay),
    .i_cfg_period (cfg_period),
    .i_ack_valid  (ack_valid),
    .i_ack_ch     (ack_ch),
    .o_irq        (irq),
    .o_busy       (busy),
    .o_timeout    (tmo)
  );

  typedef struct {
    logic [2:0] irq;
    logic       busy;
    logic [2:0] to;
    longint     n;
  } exp_t;

  exp_t   q[$];
  exp_t   mon_e;
  int     errors = 0;
  int     checks = 0;
  longint n = 0;

  int          mode[NCH];
  longint      rise_at[NCH];
  longint      high_since[NCH];
  logic [31:0] per[NCH];
  logic [2:0]  to_flag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv,
                     input longint at);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, at, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mode[c]       = M_OFF;
      rise_at[c]    = 0;
      high_since[c] = 0;
      per[c]        = 32'd0;
    end
    to_flag = 3'b000;
  endtask

  task automatic model_edge(input bit wr, input int sel, input logic [31:0] d,
                            input logic [31:0] p, input bit av, input int ach);
    for (int c = 0; c < NCH; c++) begin
      if (wr && sel == c) begin
        mode[c]    = M_WAIT;
        rise_at[c] = n + longint'({32'd0, d}) + 1;
        per[c]     = p;
      end else if (mode[c] == M_WAIT && n == rise_at[c]) begin
        mode[c]       = M_HIGH;
        high_since[c] = n;
      end else if (mode[c] == M_HIGH && av && ach == c) begin
        if (per[c] != 0) begin
          mode[c]    = M_WAIT;
          rise_at[c] = n + longint'({32'd0, per[c]}) + 1;
        end else begin
          mode[c] = M_OFF;
        end
      end else if (mode[c] == M_HIGH && TO_EN && (n - high_since[c]) == TMO) begin
        mode[c]    = M_OFF;
        to_flag[c] = 1'b1;
      end
    end
  endtask

  task automatic step(input bit wr, input int sel, input logic [31:0] d, input logic [31:0] p,
                      input bit av, input int ach);
    exp_t e;
    cfg_wr     = wr;
    cfg_sel    = 2'(sel);
    cfg_delay  = d;
    cfg_period = p;
    ack_valid  = av;
    ack_ch     = 2'(ach);
    @(posedge clk);
    n++;
    model_edge(wr, sel, d, p, av, ach);
    e.n    = n;
    e.to   = to_flag;
    e.busy = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      e.irq[c] = (mode[c] == M_HIGH);
      if (mode[c] != M_OFF) e.busy = 1'b1;
    end
    q.push_back(e);
    @(negedge clk);
    cfg_wr    = 1'b0;
    ack_valid = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 0, 32'd0, 32'd0, 1'b0, 0);
  endtask

  task automatic wait_high(input int c);
    for (int k = 0; k < 64; k++) begin
      if (mode[c] == M_HIGH) break;
      idle();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("irq", {29'd0, irq}, {29'd0, mon_e.irq}, mon_e.n);
      chk("busy", {31'd0, busy}, {31'd0, mon_e.busy}, mon_e.n);
      chk("timeout", {29'd0, tmo}, {29'd0, mon_e.to}, mon_e.n);
    end
  end

  initial begin
    bit          wr, av;
    int          sel, ach, c;
    logic [31:0] d, p;

    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_irq", {29'd0, irq}, 32'd0, n);
    chk("reset_busy", {31'd0, busy}, 32'd0, n);
    chk("reset_timeout", {29'd0, tmo}, 32'd0, n);
    rst_n = 1'b1;

    repeat (100) idle();

    // one-shot ch1, delay 5
    step(1'b1, 1, 32'd5, 32'd0, 1'b0, 0);
    repeat (8) idle();
    step(1'b0, 0, 32'd0, 32'd0, 1'b1, 1);
    repeat (3) idle();

    // periodic ch0, delay 0, period 10, three acks
    step(1'b1, 0, 32'd0, 32'd10, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      wait_high(0);
      step(1'b0, 0, 32'd0, 32'd0, 1'b1, 0);
    end
    wait_high(0);
    step(1'b1, 0, 32'd0, 32'd0, 1'b0, 0);
    step(1'b0, 0, 32'd0, 32'd0, 1'b1, 0);
    repeat (2) idle();

    // same-edge cfg and ack on ch2 while asserted
    step(1'b1, 2, 32'd0, 32'd0, 1'b0, 0);
    wait_high(2);
    step(1'b1, 2, 32'd3, 32'd0, 1'b1, 2);
    repeat (6) idle();
    step(1'b0, 0, 32'd0, 32'd0, 1'b1, 2);

    // ack to an armed channel is ignored
    step(1'b1, 0, 32'd6, 32'd0, 1'b0, 0);
    repeat (2) idle();
    step(1'b0, 0, 32'd0, 32'd0, 1'b1, 0);
    repeat (6) idle();
    step(1'b0, 0, 32'd0, 32'd0, 1'b1, 0);

    // maximum delay stays armed
    step(1'b1, 1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
    repeat (40) idle();
    step(1'b1, 1, 32'd1, 32'd0, 1'b0, 0);
    repeat (3) idle();
    step(1'b0, 0, 32'd0, 32'd0, 1'b1, 1);

    // asynchronous reset while ch0 asserted
    step(1'b1, 0, 32'd0, 32'd0, 1'b0, 0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_irq", {29'd0, irq}, 32'd0, n);
    chk("async_rst_busy", {31'd0, busy}, 32'd0, n);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // no ack: timeout (when enabled) and stickiness across reprogramming
    step(1'b1, 0, 32'd0, 32'd0, 1'b0, 0);
    repeat (25) idle();
    step(1'b1, 0, 32'd2, 32'd0, 1'b0, 0);
    repeat (5) idle();
    step(1'b0, 0, 32'd0, 32'd0, 1'b1, 0);
    repeat (2) idle();

    // ack exactly on the terminal timeout edge
    do_reset();
    step(1'b1, 0, 32'd0, 32'd0, 1'b0, 0);
    repeat (16) idle();
    step(1'b0, 0, 32'd0, 32'd0, 1'b1, 0);
    repeat (3) idle();

    // all three rise together, cleared 2,0,1; out-of-range sel/ack ignored
    step(1'b1, 0, 32'd6, 32'd0, 1'b0, 0);
    step(1'b1, 1, 32'd5, 32'd0, 1'b0, 0);
    step(1'b1, 2, 32'd4, 32'd0, 1'b0, 0);
    step(1'b1, 3, 32'd0, 32'd0, 1'b1, 3);
    repeat (5) idle();
    step(1'b0, 0, 32'd0, 32'd0, 1'b1, 2);
    idle();
    step(1'b0, 0, 32'd0, 32'd0, 1'b1, 0);
    idle();
    step(1'b0, 0, 32'd0, 32'd0, 1'b1, 1);
    repeat (2) idle();

    // random traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      wr  = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 3);
      d   = $urandom_range(0, 20);
      p   = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 15));
      av  = 1'b0;
      ach = 0;
      c   = $urandom_range(0, 2);
      if (mode[c] == M_HIGH && $urandom_range(0, 5) < 2) begin
        av  = 1'b1;
        ach = c;
      end else if ($urandom_range(0, 7) == 0) begin
        av  = 1'b1;
        ach = $urandom_range(0, 3);
      end
      step(wr, sel, d, p, av, ach);
    end

    repeat (30) idle();
    @(negedge clk);
    chk("queue_drain", 32'(q.size()), 32'd0, n);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_irq_sequencer.md
# rv32i_irq_sequencer

Synthesizable, parametrised interrupt stimulus sequencer for the rv32i_soc verification and bring-up environment. It drives NUM_CH interrupt lines into the core, such as the external, software and timer-compare request inputs. Each channel fires after a programmed cycle delay, optionally repeats with a programmed period, and holds its request until the core acknowledges the trap. The block replaces ad-hoc delay-based stimulus with a deterministic, cycle-counted, handshake-cleared source that can also sit on an FPGA build.

## Interface
Parameters:
- NUM_CH, 3: number of independent interrupt channels (1..16).
- CNT_W, 32: width of delay/period counters.
- TIMEOUT, 1024: cycles a request may stay asserted without acknowledge (≥2); used only with IRQ_SEQ_TIMEOUT_EN.

Ports:
- i_clk  in  1  single clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_cfg_wr  in  1  one-cycle strobe: (re)program channel i_cfg_sel.
- i_cfg_sel  in  $clog2(NUM_CH) (min 1)  channel index.
- i_cfg_delay  in  CNT_W  cycles from programming to request.
- i_cfg_period  in  CNT_W  re-arm period after acknowledge; 0 = one-shot.
- i_ack_valid  in  1  trap taken; system drives it from writeback-enable AND go-to-trap.
- i_ack_ch  in  $clog2(NUM_CH) (min 1)  channel acknowledged; decoded by the system from mcause.
- o_irq  out  NUM_CH  registered interrupt requests, one per channel.
- o_busy  out  1  OR of all channels not IDLE/DONE.
- o_timeout  out  NUM_CH  sticky per-channel timeout flags.

## Operation
- Per-channel FSM with states IDLE, ARMED, ASSERT and DONE. Reset puts every channel in IDLE, with counters 0, o_irq 0, o_busy 0 and o_timeout 0.
- i_cfg_wr to channel c, from any state:
  - state←ARMED, cnt←i_cfg_delay, period_reg←i_cfg_period, tcnt←0, o_irq[c]←0.
  - o_timeout[c] is not cleared.
- ARMED: if cnt==0, go to ASSERT (o_irq[c]←1); otherwise cnt←cnt−1.
- ASSERT: o_irq[c] held at 1.
  - Ack for c with period_reg≠0: go to ARMED, cnt←period_reg, o_irq[c]←0.
  - Ack for c with period_reg==0: go to DONE, o_irq[c]←0.
- DONE and IDLE: o_irq[c]=0. Leave only via i_cfg_wr.
- An ack naming a channel that is not in ASSERT is ignored.
- i_cfg_sel ≥ NUM_CH: write ignored. i_ack_ch ≥ NUM_CH: ack ignored.
- Simultaneous i_cfg_wr and ack on the same channel: cfg wins.
- Simultaneous cfg or ack on different channels: both take effect.
- Counters are unsigned, decrement only, never wrap below 0. Delay 2^CNT_W−1 is legal.
- Several channels may assert at once. Priority is the core's job; this block applies none.
- Asynchronous reset mid-operation: every channel returns to IDLE immediately and o_irq drops asynchronously.

## Timing
- Cfg sampled at edge k with delay D: o_irq[c] rises after edge k+D+1. D=0 gives a rise after edge k+1.
- Ack sampled at edge a: o_irq[c] falls after edge a. There is no combinational path from ack to irq.
- Periodic re-fire: ack at edge a, period P: o_irq[c] rises after edge a+P+1.
- o_busy is registered and tracks channel states with the same edge timing as o_irq.

## Configuration
- Macro IRQ_SEQ_TIMEOUT_EN, when defined:
  - tcnt increments in ASSERT.
  - When tcnt==TIMEOUT−1 and there is no ack at that edge: go to DONE, o_irq[c]←0, o_timeout[c]←1 (sticky until reset).
  - An ack on that same edge wins, so no timeout is recorded.
- When not defined: no tcnt logic, o_timeout tied 0, ASSERT held indefinitely until ack.

## Structure
- Shared package rv32i_irq_seq_pkg holds:
  - state encoding constants: IDLE=2'd0, ARMED=2'd1, ASSERT=2'd2, DONE=2'd3;
  - the default TIMEOUT constant.
- Sub-module rv32i_irq_seq_channel holds one FSM with cnt, period_reg, tcnt and an irq flop. Top level instantiates it NUM_CH times via generate, decodes cfg_sel and ack_ch to per-channel strobes, and ORs o_busy.

## Test plan
- Reset release, no cfg: o_irq=0, o_busy=0 for 100 cycles. Assert i_rst_n=0 while ch0 is in ASSERT -> o_irq[0]=0 immediately.
- Program ch1 delay=5, period=0 at edge k: o_irq[1] rises after edge k+6. Ack ch1 at edge a: falls after edge a. Channel stays DONE with o_busy=0.
- Program ch0 delay=0, period=10: rises after edge k+1. Acks re-fire each time 11 cycles after ack, verified over 3 periods.
- Same-edge cfg(ch2, delay=3) and ack(ch2) while ch2 is in ASSERT: o_irq[2] drops and rises 4 cycles later. Ack to ch0 while ch0 is ARMED: ignored, o_irq[0] still fires on schedule.
- IRQ_SEQ_TIMEOUT_EN, TIMEOUT=16: ch0 never acked -> o_irq[0] drops after 16 asserted cycles, o_timeout[0]=1 sticky across reprogramming. Repeat with ack at cycle 16 -> o_timeout[0]=0.
- All three channels delay=4 simultaneously: o_irq=3'b111 together. Acks in order 2,0,1 clear individually. i_cfg_sel=3 is ignored.
